// File: rtl/csr_host_sequencer_if.sv
// rtl/csr_host_sequencer_if.sv - command, register-port and result-stream bundle for csr_host_sequencer
// master = sequencer side, slave = controller / register block / result consumer side.
interface csr_host_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic        m_en;
  logic [3:0]  m_we;
  logic [12:0] m_addr;
  logic [31:0] m_wrdata;
  logic [31:0] m_rddata;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_last;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  cmd_valid, cmd_mode, m_rddata, res_ready,
    output cmd_ready, m_en, m_we, m_addr, m_wrdata,
           res_valid, res_data, res_last, busy, timeout_err
  );

  modport slave (
    output cmd_valid, cmd_mode, m_rddata, res_ready,
    input  cmd_ready, m_en, m_we, m_addr, m_wrdata,
           res_valid, res_data, res_last, busy, timeout_err
  );
endinterface

// File: rtl/csr_host_sequencer.sv
// rtl/csr_host_sequencer.sv - write mode, pulse start, poll finish, stream result registers
// Port outputs are decoded only from registered state so there is no input-to-output path.
module csr_host_sequencer #(
  parameter int POLL_LIMIT = 1024,
  parameter int RD_BASE    = 9,
  parameter int RD_COUNT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  csr_host_sequencer_if.master bus
);

  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int IW = (RD_COUNT > 1) ? $clog2(RD_COUNT) : 1;
  localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_LIMIT);
  localparam logic [IW-1:0] LAST_IDX  = IW'(RD_COUNT - 1);
  localparam logic [12:0]   RD_BASE_A = 13'(RD_BASE);

  typedef enum logic [3:0] {
    IDLE, WR_MODE, WR_START1, WR_START0, POLL_RD, POLL_WAIT, RES_RD, RES_WAIT, RES_OUT
  } state_t;

  state_t        state, state_n;
  logic [1:0]    mode, mode_n;
  logic [PW-1:0] poll_cnt, poll_n;
  logic          seen_busy, seen_n;
  logic [IW-1:0] idx, idx_n;
  logic [31:0]   res_q, res_n;
  logic          tmo_q, tmo_n;

  logic          cmd_ready_c, m_en_c, res_valid_c, res_last_c;
  logic [3:0]    m_we_c;
  logic [12:0]   m_addr_c;
  logic [31:0]   m_wrdata_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= '0;
      poll_cnt  <= '0;
      seen_busy <= 1'b0;
      idx       <= '0;
      res_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      poll_cnt  <= poll_n;
      seen_busy <= seen_n;
      idx       <= idx_n;
      res_q     <= res_n;
      tmo_q     <= tmo_n;
    end
  end

  always_comb begin
    state_n     = state;
    mode_n      = mode;
    poll_n      = poll_cnt;
    seen_n      = seen_busy;
    idx_n       = idx;
    res_n       = res_q;
    tmo_n       = tmo_q;
    cmd_ready_c = 1'b0;
    m_en_c      = 1'b0;
    m_we_c      = 4'h0;
    m_addr_c    = '0;
    m_wrdata_c  = '0;
    res_valid_c = 1'b0;
    res_last_c  = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          mode_n  = bus.cmd_mode;
          tmo_n   = 1'b0;
          poll_n  = '0;
          seen_n  = 1'b0;
          idx_n   = '0;
          state_n = WR_MODE;
        end
      end
      WR_MODE: begin
        m_en_c     = 1'b1;
        m_we_c     = 4'hF;
        m_addr_c   = 13'd3;
        m_wrdata_c = {30'd0, mode};
        state_n    = WR_START1;
      end
      WR_START1: begin
        m_en_c     = 1'b1;
        m_we_c     = 4'hF;
        m_addr_c   = 13'd1;
        m_wrdata_c = 32'd1;
        state_n    = WR_START0;
      end
      WR_START0: begin
        m_en_c   = 1'b1;
        m_we_c   = 4'hF;
        m_addr_c = 13'd1;
        state_n  = POLL_RD;
      end
      POLL_RD: begin
        m_en_c   = 1'b1;
        m_addr_c = 13'd4;
        if (poll_cnt != POLL_MAX) poll_n = poll_cnt + PW'(1);
        state_n  = POLL_WAIT;
      end
      POLL_WAIT: begin
        // A finish bit seen before any busy sample is the stale pre-start value.
        if (!bus.m_rddata[0]) seen_n = 1'b1;
        if (bus.m_rddata[0] && seen_busy) begin
          idx_n   = '0;
          state_n = RES_RD;
        end else if (poll_cnt == POLL_MAX) begin
          tmo_n   = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = POLL_RD;
        end
      end
      RES_RD: begin
        m_en_c   = 1'b1;
        m_addr_c = RD_BASE_A + {{(13-IW){1'b0}}, idx};
        state_n  = RES_WAIT;
      end
      RES_WAIT: begin
        res_n   = bus.m_rddata;
        state_n = RES_OUT;
      end
      RES_OUT: begin
        res_valid_c = 1'b1;
        res_last_c  = (idx == LAST_IDX);
        if (bus.res_ready) begin
          if (idx == LAST_IDX) begin
            state_n = IDLE;
          end else begin
            idx_n   = idx + IW'(1);
            state_n = RES_RD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_c;
  assign bus.m_en        = m_en_c;
  assign bus.m_we        = m_we_c;
  assign bus.m_addr      = m_addr_c;
  assign bus.m_wrdata    = m_wrdata_c;
  assign bus.res_valid   = res_valid_c;
  assign bus.res_data    = res_q;
  assign bus.res_last    = res_last_c;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = tmo_q;

endmodule
